// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - ARM pipeline memory-access stage with MEM/WB register
// Runs req/ack data-memory transactions for loads/stores and freezes upstream while outstanding.
module mem_stage #(
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       val_rm_in,
  input  logic [3:0]        dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              freeze,
  output logic              bus_err,
  output logic              wb_en_out,
  output logic              mem_read_en_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data_out,
  output logic [3:0]        dest_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             access;

  assign access = mem_read_en_in | mem_write_en_in;

  // Held low during reset so an aborted transaction never leaves the pipe stalled.
  assign freeze = ~rst & (((state == IDLE) & access) | (state == WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rdata_q         <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      bus_err         <= 1'b0;
      wb_en_out       <= 1'b0;
      mem_read_en_out <= 1'b0;
      alu_res_out     <= '0;
      mem_data_out    <= '0;
      dest_out        <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            // Read wins when both enables are set.
            mem_req         <= 1'b1;
            mem_we          <= ~mem_read_en_in;
            mem_addr        <= ADDR_W'((alu_res_in - 32'(BASE_ADDR)) >> 2);
            mem_wdata       <= val_rm_in;
            cnt             <= '0;
            state           <= WAIT;
            wb_en_out       <= 1'b0;
            mem_read_en_out <= 1'b0;
          end else begin
            wb_en_out       <= wb_en_in;
            mem_read_en_out <= mem_read_en_in;
            alu_res_out     <= alu_res_in;
            dest_out        <= dest_in;
            mem_data_out    <= '0;
          end
        end
        WAIT: begin
          wb_en_out       <= 1'b0;
          mem_read_en_out <= 1'b0;
          cnt             <= cnt + 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_we ? 32'd0 : mem_rdata;
            state   <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            rdata_q <= '0;
            bus_err <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          wb_en_out       <= wb_en_in;
          mem_read_en_out <= mem_read_en_in;
          alu_res_out     <= alu_res_in;
          dest_out        <= dest_in;
          mem_data_out    <= rdata_q;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_read_en_in, mem_write_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack, freeze, bus_err;
  logic        wb_en_out, mem_read_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.BASE_ADDR(1024), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze), .bus_err(bus_err),
    .wb_en_out(wb_en_out), .mem_read_en_out(mem_read_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dest_out(dest_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wb_en_in = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
    alu_res_in = '0; val_rm_in = '0; dest_in = '0;
  endtask

  // Presents one memory instruction in IDLE; acked in the k-th WAIT cycle.
  task automatic mem_op(input logic rd, input logic wr, input logic wb,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] dst,
                        input int k, input logic [31:0] rdat, input logic [31:0] exp_addr);
    wb_en_in = wb; mem_read_en_in = rd; mem_write_en_in = wr;
    alu_res_in = addr; val_rm_in = wd; dest_in = dst;
    #1;
    check("op_freeze_idle", {31'b0, freeze}, 32'd1);
    check("op_req_idle", {31'b0, mem_req}, 32'd0);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      check("op_req_wait", {31'b0, mem_req}, 32'd1);
      check("op_freeze_wait", {31'b0, freeze}, 32'd1);
      check("op_bubble", {31'b0, wb_en_out}, 32'd0);
      check("op_we", {31'b0, mem_we}, rd ? 32'd0 : 32'd1);
      check("op_addr", {16'b0, mem_addr}, exp_addr);
      check("op_wdata", mem_wdata, wd);
      if (c == k) begin
        mem_ack = 1'b1; mem_rdata = rdat;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    check("op_req_done", {31'b0, mem_req}, 32'd0);
    check("op_freeze_done", {31'b0, freeze}, 32'd0);
    check("op_buserr_done", {31'b0, bus_err}, 32'd0);
    check("op_bubble_done", {31'b0, wb_en_out}, 32'd0);
    @(negedge clk);
    check("op_wb_en_out", {31'b0, wb_en_out}, {31'b0, wb});
    check("op_mem_read_out", {31'b0, mem_read_en_out}, {31'b0, rd});
    check("op_mem_data_out", mem_data_out, rd ? rdat : 32'd0);
    check("op_alu_res_out", alu_res_out, addr);
    check("op_dest_out", {28'b0, dest_out}, {28'b0, dst});
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_freeze", {31'b0, freeze}, 32'd0);
    check("rst_wb_en_out", {31'b0, wb_en_out}, 32'd0);
    check("rst_mem_read_out", {31'b0, mem_read_en_out}, 32'd0);
    check("rst_alu_res_out", alu_res_out, 32'd0);
    check("rst_mem_data_out", mem_data_out, 32'd0);
    check("rst_dest_out", {28'b0, dest_out}, 32'd0);
    rst = 1'b0;

    // Plain ALU instruction passes through in one cycle.
    wb_en_in = 1'b1; alu_res_in = 32'h1234; dest_in = 4'd5;
    #1 check("alu_freeze", {31'b0, freeze}, 32'd0);
    @(negedge clk);
    check("alu_wb_en_out", {31'b0, wb_en_out}, 32'd1);
    check("alu_res_out", alu_res_out, 32'h1234);
    check("alu_dest_out", {28'b0, dest_out}, 32'd5);
    check("alu_mem_data_out", mem_data_out, 32'd0);
    check("alu_freeze2", {31'b0, freeze}, 32'd0);
    idle_inputs();

    // Stray ack in IDLE is ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_req", {31'b0, mem_req}, 32'd0);
    check("idle_ack_freeze", {31'b0, freeze}, 32'd0);

    mem_op(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd3, 3, 32'hDEADBEEF, 32'd2);
    mem_op(1'b0, 1'b1, 1'b0, 32'd1024, 32'hA5A5A5A5, 4'd0, 1, 32'h12345678, 32'd0);
    mem_op(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd1, 1, 32'h11112222, 32'd1);
    mem_op(1'b1, 1'b0, 1'b1, 32'd1027, 32'h0, 4'd2, 1, 32'h33334444, 32'd0);
    // Below BASE_ADDR wraps; ack coincides with the timeout cycle.
    mem_op(1'b1, 1'b0, 1'b1, 32'd0, 32'h0, 4'd4, 4, 32'h55556666, 32'h0000FF00);
    mem_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h77778888, 4'd6, 2, 32'h9999AAAA, 32'd3);

    // Timeout: never acked.
    wb_en_in = 1'b1; mem_read_en_in = 1'b1; alu_res_in = 32'd1040; dest_in = 4'd7;
    #1 check("to_freeze_idle", {31'b0, freeze}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("to_req_wait", {31'b0, mem_req}, 32'd1);
      check("to_freeze_wait", {31'b0, freeze}, 32'd1);
      check("to_buserr_wait", {31'b0, bus_err}, 32'd0);
    end
    @(negedge clk);
    check("to_req_done", {31'b0, mem_req}, 32'd0);
    check("to_buserr_done", {31'b0, bus_err}, 32'd1);
    check("to_freeze_done", {31'b0, freeze}, 32'd0);
    @(negedge clk);
    check("to_buserr_after", {31'b0, bus_err}, 32'd0);
    check("to_mem_data_out", mem_data_out, 32'd0);
    check("to_wb_en_out", {31'b0, wb_en_out}, 32'd1);
    check("to_alu_res_out", alu_res_out, 32'd1040);
    idle_inputs();

    // Reset mid-WAIT abandons the transaction immediately.
    wb_en_in = 1'b1; mem_read_en_in = 1'b1; alu_res_in = 32'd1044; dest_in = 4'd9;
    repeat (2) @(negedge clk);
    check("rw_req_before", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rw_req", {31'b0, mem_req}, 32'd0);
    check("rw_freeze", {31'b0, freeze}, 32'd0);
    check("rw_alu_res_out", alu_res_out, 32'd0);
    check("rw_dest_out", {28'b0, dest_out}, 32'd0);
    check("rw_mem_addr", {16'b0, mem_addr}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    mem_op(1'b1, 1'b0, 1'b1, 32'd1048, 32'h0, 4'd10, 2, 32'hCAFEF00D, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the ARM pipeline and the consumer of the EX/MEM pipeline register. It takes the registered EX-stage results (control bits, ALU result, Rm value, destination), runs a req/ack transaction on the external data-memory port for loads and stores, and freezes the upstream pipeline while a transaction is outstanding. It also contains the MEM/WB pipeline register, which feeds write-back.

## Interface
- BASE_ADDR, 1024: byte offset subtracted from alu_res_in to form the memory address.
- ADDR_W, 16: width of the word address presented to memory.
- TIMEOUT, 16: maximum number of WAIT cycles before the transaction is abandoned (≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_en_in, mem_read_en_in, mem_write_en_in  in  1 each  control bits from the EX/MEM register.
- alu_res_in  in  32  ALU result; used as the byte address for loads and stores.
- val_rm_in  in  32  store data.
- dest_in  in  4  destination register.
- mem_req  out  1  memory request; held high until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  word address, ((alu_res_in − BASE_ADDR) >> 2) truncated to ADDR_W.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled only in the ack cycle.
- mem_ack  in  1  one-cycle acknowledge.
- freeze  out  1  stall for the upstream pipeline registers (combinational).
- bus_err  out  1  one-cycle pulse on timeout.
- wb_en_out, mem_read_en_out  out  1 each  MEM/WB control bits.
- alu_res_out, mem_data_out  out  32 each  MEM/WB ALU result and loaded data.
- dest_out  out  4  MEM/WB destination.

## Operation
- access = mem_read_en_in | mem_write_en_in. If both enable bits are set, the access is treated as a read.
- FSM states: IDLE, WAIT, DONE.
- **IDLE, no access**
  - MEM/WB loads wb_en_in, mem_read_en_in (0), alu_res_in and dest_in.
  - mem_data_out loads 0.
  - freeze = 0.
- **IDLE, access**
  - Registers mem_req←1, mem_we←~mem_read_en_in, mem_addr and mem_wdata←val_rm_in.
  - Clears the timeout counter and goes to WAIT.
  - freeze = 1.
  - MEM/WB loads a bubble: all control bits 0. Data fields hold their previous values.
- **WAIT**
  - freeze = 1. MEM/WB loads a bubble every cycle.
  - Counter increments each cycle.
  - On mem_ack: mem_req←0, rdata_q←mem_rdata for a read or 0 for a write, go to DONE.
  - If the counter reaches TIMEOUT−1 without mem_ack: mem_req←0, rdata_q←0, bus_err pulses for 1 cycle, go to DONE.
  - If mem_ack and timeout occur in the same cycle, ack wins and there is no bus_err.
- **DONE**
  - freeze = 0.
  - MEM/WB loads wb_en_in, mem_read_en_in, alu_res_in, dest_in and mem_data_out←rdata_q.
  - Goes to IDLE unconditionally. The upstream register advances on this edge.
- mem_ack in IDLE or DONE is ignored.
- Inputs are stable throughout WAIT and DONE because the upstream register is frozen. The block does not re-sample mem_addr or mem_wdata after IDLE.
- Address arithmetic is 32-bit modulo-2^32 subtraction, then a logical right shift by 2. The low two bits are ignored, so misaligned addresses are silently word-aligned.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - mem_req, mem_we, bus_err 0; mem_addr, mem_wdata 0.
  - All MEM/WB outputs 0.
  - freeze is 0 after reset. Being combinational, it follows the IDLE access rule once rst is released.
- Reset asserted mid-WAIT: mem_req drops immediately (asynchronously) and the transaction is abandoned. The memory model must tolerate a dropped request.
- Non-memory instruction: 1 cycle, same as a plain pipeline register.
- Memory instruction with ack k cycles after mem_req rises (k ≥ 1):
  - IDLE 1 cycle + WAIT k cycles + DONE 1 cycle.
  - freeze is high for k+1 cycles.
  - The MEM/WB result is visible k+2 edges after the instruction arrives.
- mem_req rises on the edge after the instruction is presented and falls on the edge after mem_ack.
- Back-to-back memory instructions: IDLE is revisited between them, so there is no back-to-back req.
- Timeout: bus_err is high during the first DONE cycle. freeze is high for TIMEOUT+1 cycles in total.

## Test plan
- ALU op: wb_en_in=1, alu_res_in=0x1234, dest_in=5, no memory enables → the next edge gives wb_en_out=1, alu_res_out=0x1234, dest_out=5, mem_data_out=0, freeze never 1.
- Load: alu_res_in=1032, mem_read_en_in=1, mem_ack with mem_rdata=0xDEADBEEF on the 3rd cycle of mem_req → mem_addr=2, mem_we=0, freeze high for 4 cycles, then mem_data_out=0xDEADBEEF, mem_read_en_out=1; bubbles (wb_en_out=0) meanwhile.
- Store: alu_res_in=1024, val_rm_in=0xA5A5A5A5, immediate ack → mem_we=1, mem_addr=0, mem_wdata=0xA5A5A5A5, freeze for 2 cycles, mem_data_out=0, wb_en_out=0.
- Two consecutive loads, each acked after 1 cycle → two separate mem_req pulses with an IDLE cycle between them, both results written back in order.
- Timeout: TIMEOUT=4, never ack → mem_req drops after 4 WAIT cycles, bus_err pulses 1 cycle, mem_data_out=0, pipeline resumes.
- rst pulsed during WAIT → mem_req, freeze and all outputs go to 0 immediately; the next instruction after reset is processed normally.
